// File: rtl/cpu_mem_arbiter_if.sv
// Purpose : bundles the CPU fetch/data ports, the shared memory-bus master port and the stall counter.
// Latency : n/a (signal bundle only).
// Backpressure: n/a; im_stall/dm_stall freeze the CPU, mem_gnt/mem_rvalid pace the bus.
// Ports   : master = arbiter view (drives stalls, read data, bus request/payload, counter);
//           slave  = CPU-plus-bus view (drives requests, gnt, rvalid, rdata).
interface cpu_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
);
   // CPU instruction fetch side
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] im_instr;
   logic              im_stall;
   // CPU data side
   logic              dm_req;
   logic              dm_write;
   logic [3:0]        dm_bweb;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_stall;
   // shared memory bus
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_bweb;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   // statistics
   logic [CNT_W-1:0]  stall_cycles;

   modport master (
      input  if_req, if_addr, dm_req, dm_write, dm_bweb, dm_addr, dm_wdata,
             mem_gnt, mem_rvalid, mem_rdata,
      output im_instr, im_stall, dm_rdata, dm_stall,
             mem_req, mem_we, mem_bweb, mem_addr, mem_wdata, stall_cycles
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_write, dm_bweb, dm_addr, dm_wdata,
             mem_gnt, mem_rvalid, mem_rdata,
      input  im_instr, im_stall, dm_rdata, dm_stall,
             mem_req, mem_we, mem_bweb, mem_addr, mem_wdata, stall_cycles
   );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Purpose : shares one single-outstanding memory bus between CPU fetch (IF) and data (DM) ports.
// Latency : request seen cycle 0 -> mem_req cycle 1; stall drops the cycle after gnt (write) or rvalid (read).
// Backpressure: mem_req/payload held until mem_gnt; CPU frozen via im_stall/dm_stall until its access completes.
// Ports   : clk, rst (sync, active-high); bus = cpu_mem_arbiter_if.master carrying all CPU/bus signals.
module cpu_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input logic                clk,
   input logic                rst,
   cpu_mem_arbiter_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic              owner_dm;     // 1 = current transaction belongs to DM, 0 = IF
   logic              if_done;
   logic              dm_done;

   logic              mem_req_q;
   logic              mem_we_q;
   logic [3:0]        mem_bweb_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] im_instr_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic [CNT_W-1:0]  stall_cnt;

   logic              pend_if;
   logic              pend_dm;
   logic              release_cyc;

   // A requester is pending until its done flag is set; done flags keep a
   // completed access from being reissued while the pipeline stays frozen.
   always_comb begin
      pend_dm     = bus.dm_req & ~dm_done;
      pend_if     = bus.if_req & ~if_done;
      // Nothing left outstanding while the CPU still presents a request:
      // the pipeline advances this cycle, so the done flags are retired.
      release_cyc = ~pend_if & ~pend_dm & (bus.if_req | bus.dm_req);
   end

   assign bus.im_stall     = pend_if;
   assign bus.dm_stall     = pend_dm;
   assign bus.mem_req      = mem_req_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_bweb     = mem_bweb_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.im_instr     = im_instr_q;
   assign bus.dm_rdata     = dm_rdata_q;
   assign bus.stall_cycles = stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner_dm    <= 1'b0;
         if_done     <= 1'b0;
         dm_done     <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_bweb_q  <= 4'hF;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         im_instr_q  <= '0;
         dm_rdata_q  <= '0;
         stall_cnt   <= '0;
      end else begin
         if ((pend_if | pend_dm) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end

         // Placed before the FSM so a completion in the same cycle wins.
         if (release_cyc) begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
         end

         case (state)
            IDLE: begin
               // DM is the older instruction in the pipeline, so it wins ties.
               if (pend_dm) begin
                  owner_dm    <= 1'b1;
                  state       <= REQ;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.dm_write;
                  mem_bweb_q  <= bus.dm_write ? bus.dm_bweb : 4'hF;
                  mem_addr_q  <= bus.dm_addr;
                  mem_wdata_q <= bus.dm_wdata;
               end else if (pend_if) begin
                  owner_dm    <= 1'b0;
                  state       <= REQ;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_bweb_q  <= 4'hF;
                  mem_addr_q  <= bus.if_addr;
                  mem_wdata_q <= '0;
               end
            end

            REQ: begin
               if (bus.mem_gnt) begin
                  mem_req_q <= 1'b0;
                  if (mem_we_q) begin
                     // Writes complete on acceptance; no response phase.
                     if (owner_dm) dm_done <= 1'b1;
                     else          if_done <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= RESP;
                  end
               end
            end

            RESP: begin
               if (bus.mem_rvalid) begin
                  if (owner_dm) begin
                     dm_rdata_q <= bus.mem_rdata;
                     dm_done    <= 1'b1;
                  end else begin
                     im_instr_q <= bus.mem_rdata;
                     if_done    <= 1'b1;
                  end
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Purpose : directed self-checking bench for cpu_mem_arbiter (CNT_W=4 so saturation is reachable).
// Latency : inputs driven 1ns after posedge, outputs sampled 1ns later, well away from the edge.
// Backpressure: bench plays both the CPU (holds requests while stalled) and the bus (gnt/rvalid).
module tb_cpu_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   gnt_cnt;

   cpu_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   cpu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count accepted bus transactions.
   initial gnt_cnt = 0;
   always @(posedge clk) begin
      if (!rst && bus.mem_req && bus.mem_gnt) gnt_cnt = gnt_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
      checks++; if (bus.mem_bweb !== 4'hF) begin failures++; $display("FAIL rst_mem_bweb: got %h expected f", bus.mem_bweb); end
      checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
      checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
      checks++; if (bus.im_instr !== 32'h0) begin failures++; $display("FAIL rst_im_instr: got %h expected 0", bus.im_instr); end
      checks++; if (bus.dm_rdata !== 32'h0) begin failures++; $display("FAIL rst_dm_rdata: got %h expected 0", bus.dm_rdata); end
      checks++; if (bus.stall_cycles !== 4'h0) begin failures++; $display("FAIL rst_stall_cycles: got %h expected 0", bus.stall_cycles); end
      checks++; if ({bus.im_stall, bus.dm_stall} !== 2'b00) begin failures++; $display("FAIL rst_stalls: got %b expected 00", {bus.im_stall, bus.dm_stall}); end
      rst = 1'b0;
   endtask

   task automatic test_single_fetch();
      // cycle 0: fetch seen
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      #1;
      checks++; if (bus.im_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_c0: got %b expected 1", bus.im_stall); end
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_req_c0: got %b expected 0", bus.mem_req); end
      tick();
      // cycle 1: request on bus, granted
      bus.mem_gnt = 1'b1;
      #1;
      checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL fetch_req_c1: got %b expected 1", bus.mem_req); end
      checks++; if (bus.mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_addr_c1: got %h expected 100", bus.mem_addr); end
      checks++; if ({bus.mem_we, bus.mem_bweb} !== 5'b0_1111) begin failures++; $display("FAIL fetch_we_bweb_c1: got %b expected 01111", {bus.mem_we, bus.mem_bweb}); end
      tick();
      // cycle 2: response
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0013;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_req_c2: got %b expected 0", bus.mem_req); end
      checks++; if (bus.im_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_c2: got %b expected 1", bus.im_stall); end
      tick();
      // cycle 3: complete, release cycle
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
      #1;
      checks++; if (bus.im_stall !== 1'b0) begin failures++; $display("FAIL fetch_stall_c3: got %b expected 0", bus.im_stall); end
      checks++; if (bus.im_instr !== 32'h0000_0013) begin failures++; $display("FAIL fetch_instr_c3: got %h expected 00000013", bus.im_instr); end
      checks++; if (bus.stall_cycles !== 4'd3) begin failures++; $display("FAIL fetch_stall_cycles: got %0d expected 3", bus.stall_cycles); end
      tick();
      bus.if_req = 1'b0;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_no_reissue: got %b expected 0", bus.mem_req); end
      tick();
   endtask

   task automatic test_simultaneous();
      int base;
      base = gnt_cnt;
      // cycle 0: both request
      bus.if_req = 1'b1; bus.if_addr = 32'h200;
      bus.dm_req = 1'b1; bus.dm_write = 1'b0; bus.dm_addr = 32'h8000;
      #1;
      checks++; if ({bus.im_stall, bus.dm_stall} !== 2'b11) begin failures++; $display("FAIL sim_stalls_c0: got %b expected 11", {bus.im_stall, bus.dm_stall}); end
      tick();
      // cycle 1: DM issued first
      bus.mem_gnt = 1'b1;
      #1;
      checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL sim_req_c1: got %b expected 1", bus.mem_req); end
      checks++; if (bus.mem_addr !== 32'h8000) begin failures++; $display("FAIL sim_dm_first_addr: got %h expected 8000", bus.mem_addr); end
      tick();
      // cycle 2: DM data
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
      tick();
      // cycle 3: DM done, IF still stalled
      bus.mem_rvalid = 1'b0;
      #1;
      checks++; if ({bus.im_stall, bus.dm_stall} !== 2'b10) begin failures++; $display("FAIL sim_stalls_c3: got %b expected 10", {bus.im_stall, bus.dm_stall}); end
      checks++; if (bus.dm_rdata !== 32'h1234_5678) begin failures++; $display("FAIL sim_dm_rdata: got %h expected 12345678", bus.dm_rdata); end
      tick();
      // cycle 4: IF issued
      bus.mem_gnt = 1'b1;
      #1;
      checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL sim_if_req_c4: got %b expected 1", bus.mem_req); end
      checks++; if (bus.mem_addr !== 32'h200) begin failures++; $display("FAIL sim_if_addr_c4: got %h expected 200", bus.mem_addr); end
      tick();
      // cycle 5: IF data
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hABCD_0001;
      #1;
      checks++; if (bus.dm_stall !== 1'b0) begin failures++; $display("FAIL sim_dm_held_c5: got %b expected 0", bus.dm_stall); end
      tick();
      // cycle 6: both done -> release cycle
      bus.mem_rvalid = 1'b0;
      #1;
      checks++; if ({bus.im_stall, bus.dm_stall} !== 2'b00) begin failures++; $display("FAIL sim_stalls_c6: got %b expected 00", {bus.im_stall, bus.dm_stall}); end
      checks++; if (bus.im_instr !== 32'hABCD_0001) begin failures++; $display("FAIL sim_im_instr: got %h expected abcd0001", bus.im_instr); end
      tick();
      // cycle 7: done flags cleared, held requests look fresh again
      #1;
      checks++; if ({bus.im_stall, bus.dm_stall} !== 2'b11) begin failures++; $display("FAIL sim_done_cleared: got %b expected 11", {bus.im_stall, bus.dm_stall}); end
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      tick();
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL sim_req_c8: got %b expected 0", bus.mem_req); end
      checks++; if (gnt_cnt - base !== 2) begin failures++; $display("FAIL sim_txn_count: got %0d expected 2", gnt_cnt - base); end
      tick();
   endtask

   task automatic test_write();
      bus.dm_req = 1'b1; bus.dm_write = 1'b1; bus.dm_bweb = 4'b1100;
      bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
      #1;
      checks++; if (bus.dm_stall !== 1'b1) begin failures++; $display("FAIL wr_stall_c0: got %b expected 1", bus.dm_stall); end
      tick();
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) bus.mem_gnt = 1'b1;
         #1;
         checks++;
         if ({bus.mem_req, bus.mem_we, bus.mem_bweb, bus.mem_addr, bus.mem_wdata, bus.dm_stall} !==
             {1'b1, 1'b1, 4'b1100, 32'h40, 32'hDEAD_BEEF, 1'b1}) begin
            failures++;
            $display("FAIL wr_hold_c%0d: got req=%b we=%b bweb=%b addr=%h wdata=%h stall=%b expected 1 1 1100 00000040 deadbeef 1",
                     c, bus.mem_req, bus.mem_we, bus.mem_bweb, bus.mem_addr, bus.mem_wdata, bus.dm_stall);
         end
         tick();
      end
      bus.mem_gnt = 1'b0;
      #1;
      checks++; if (bus.dm_stall !== 1'b0) begin failures++; $display("FAIL wr_stall_after_gnt: got %b expected 0", bus.dm_stall); end
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL wr_req_after_gnt: got %b expected 0", bus.mem_req); end
      checks++; if (bus.dm_rdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_rdata_kept: got %h expected 12345678", bus.dm_rdata); end
      tick();
      bus.dm_req = 1'b0; bus.dm_write = 1'b0; bus.dm_bweb = 4'hF;
      tick();
   endtask

   task automatic test_stray_rvalid();
      logic [CNT_W-1:0] base;
      base = bus.stall_cycles;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
      #1;
      checks++; if (bus.im_instr !== 32'hABCD_0001) begin failures++; $display("FAIL stray_im_instr: got %h expected abcd0001", bus.im_instr); end
      checks++; if (bus.dm_rdata !== 32'h1234_5678) begin failures++; $display("FAIL stray_dm_rdata: got %h expected 12345678", bus.dm_rdata); end
      checks++; if ({bus.mem_req, bus.im_stall, bus.dm_stall} !== 3'b000) begin failures++; $display("FAIL stray_req_stalls: got %b expected 000", {bus.mem_req, bus.im_stall, bus.dm_stall}); end
      checks++; if (bus.stall_cycles !== base) begin failures++; $display("FAIL stray_stall_cycles: got %h expected %h", bus.stall_cycles, base); end
      // FSM still in IDLE: a fresh fetch is issued on the next cycle
      bus.if_req = 1'b1; bus.if_addr = 32'h500;
      tick();
      bus.mem_gnt = 1'b1;
      #1;
      checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h500}) begin failures++; $display("FAIL stray_next_fetch: got req=%b addr=%h expected 1 00000500", bus.mem_req, bus.mem_addr); end
      tick();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h66;
      tick();
      bus.mem_rvalid = 1'b0;
      #1;
      checks++; if (bus.im_instr !== 32'h66) begin failures++; $display("FAIL stray_next_instr: got %h expected 00000066", bus.im_instr); end
      tick();
      bus.if_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_in_resp();
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      tick();
      bus.mem_gnt = 1'b1;
      tick();
      // now in RESP; reset instead of data
      bus.mem_gnt = 1'b0; rst = 1'b1; bus.if_req = 1'b0;
      tick();
      rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAA;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rr_mem_req: got %b expected 0", bus.mem_req); end
      checks++; if (bus.im_instr !== 32'h0) begin failures++; $display("FAIL rr_im_instr_c0: got %h expected 0", bus.im_instr); end
      checks++; if (bus.stall_cycles !== 4'h0) begin failures++; $display("FAIL rr_stall_cycles: got %h expected 0", bus.stall_cycles); end
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
      #1;
      checks++; if (bus.im_instr !== 32'h0) begin failures++; $display("FAIL rr_rvalid_ignored: got %h expected 0", bus.im_instr); end
      checks++; if ({bus.mem_req, bus.im_stall} !== 2'b00) begin failures++; $display("FAIL rr_idle: got %b expected 00", {bus.mem_req, bus.im_stall}); end
      tick();
   endtask

   task automatic test_counter_saturation();
      int exp_cnt;
      bus.if_req = 1'b1; bus.if_addr = 32'h600; bus.mem_gnt = 1'b0;
      for (int k = 0; k <= (1 << CNT_W) + 5; k++) begin
         #1;
         exp_cnt = (k > 15) ? 15 : k;
         checks++;
         if (bus.stall_cycles !== exp_cnt[CNT_W-1:0]) begin
            failures++;
            $display("FAIL sat_count_k%0d: got %0d expected %0d", k, bus.stall_cycles, exp_cnt);
         end
         tick();
      end
      #1;
      checks++; if ({bus.mem_req, bus.im_stall} !== 2'b11) begin failures++; $display("FAIL sat_still_waiting: got %b expected 11", {bus.mem_req, bus.im_stall}); end
      rst = 1'b1; bus.if_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst            = 1'b1;
      bus.if_req     = 1'b0;
      bus.if_addr    = '0;
      bus.dm_req     = 1'b0;
      bus.dm_write   = 1'b0;
      bus.dm_bweb    = 4'hF;
      bus.dm_addr    = '0;
      bus.dm_wdata   = '0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;

      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_write();
      test_stray_rvalid();
      test_reset_in_resp();
      test_counter_saturation();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-ported memory-bus master interface between the CPU instruction fetch (IM) and data access (DM) ports.
- Generates the CPU's IM_stall/DM_stall and returns IM_instr/DM_DO data.
- Sits between the CPU core and the bus/SRAM wrapper. It sequences at most one outstanding bus transaction.
- Completed results are held until the frozen pipeline advances, so no access is replayed.

Parameters:
ADDR_W, 32, address width for both requesters and the bus
DATA_W, 32, data width
CNT_W, 32, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request; held while im_stall=1
if_addr  in  ADDR_W  fetch address (progcnt_out)
im_instr  out  DATA_W  fetched instruction, registered
im_stall  out  1  fetch not yet complete
dm_req  in  1  data request (read or write); held while dm_stall=1
dm_write  in  1  1=write, 0=read
dm_bweb  in  4  byte write enable, active-low
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  load data, registered
dm_stall  out  1  data access not yet complete
mem_req  out  1  bus request, registered
mem_we  out  1  bus write
mem_bweb  out  4  bus byte enables, active-low; 4'hF on reads
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_gnt  in  1  bus accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
stall_cycles  out  CNT_W  cycles with im_stall|dm_stall, saturating

Behaviour:
- Reset: state=IDLE; all outputs 0 except mem_bweb=4'hF; done flags and owner cleared.
- FSM states:
  - IDLE: selects the next requester.
  - REQ: mem_req=1, payload held stable until mem_gnt.
  - RESP: waits for mem_rvalid on a read.
- Pending set: pend_dm = dm_req & ~dm_done; pend_if = if_req & ~if_done.
- Stall outputs (combinational): im_stall = pend_if; dm_stall = pend_dm.
- IDLE transition: if pend_dm, owner=DM, go to REQ; else if pend_if, owner=IF, go to REQ. DM always wins ties because it is the older instruction.
- mem_* payload is captured from the owner's inputs on the IDLE->REQ edge, so mem_req first rises one cycle after the request is seen.
- REQ with mem_gnt:
  - Write: set owner done flag; go to IDLE.
  - Read: go to RESP.
  - mem_req drops in the cycle after gnt.
- RESP with mem_rvalid: capture mem_rdata into im_instr or dm_rdata (per owner); set owner done flag; go to IDLE.
- mem_rvalid in IDLE or REQ is ignored.
- Done flags are registered, so the stall deasserts the cycle after gnt (write) or rvalid (read).
- Minimum read latency: request seen at cycle 0, gnt at cycle 1, rvalid at cycle 2 → stall low at cycle 3.
- Release: in a cycle where pend_if=0, pend_dm=0 and (if_req|dm_req)=1, the pipeline advances. Both done flags clear at the next edge.
- No new transaction starts in a release cycle, because the done flags are still set.
- Both requesters pending: DM is served first and dm_stall falls, but im_stall stays high. dm_done stays set, so the DM access is not reissued while the pipeline is frozen. IF is served next.
- Requester deasserting while pending, with the transaction not yet issued: the request is dropped. Once in REQ/RESP, the transaction completes and its result is stored.
- im_instr/dm_rdata hold their value until the next completing read of the same owner. Writes do not modify dm_rdata.
- stall_cycles increments each cycle (im_stall|dm_stall)=1 and saturates at all-ones.
- rst mid-transaction: the FSM returns to IDLE and mem_req drops at the next edge. A later rvalid of the abandoned transaction is ignored.

Test Plan:
1. Single fetch: if_req=1, if_addr=0x100, gnt at cycle 1, rvalid at cycle 2 with 0x00000013 → mem_req high only at cycle 1; im_stall high cycles 0-2, low cycle 3; im_instr=0x00000013.
2. Simultaneous: if_req and dm_req read 0x8000 at cycle 0 → DM issued first (mem_addr=0x8000). dm_stall low after its rvalid while im_stall stays high. IF then issued. Done flags clear after the release cycle; exactly 2 bus transactions.
3. Write: dm_write=1, dm_bweb=4'b1100, wdata=0xDEADBEEF, gnt delayed 3 cycles → mem_req and payload stable 3 cycles; dm_stall low the cycle after gnt; dm_rdata unchanged.
4. Stray rvalid: pulse mem_rvalid=1 with data 0x55 while IDLE → no output or state change.
5. Reset in RESP: assert rst for 1 cycle, then rvalid with 0xAA → mem_req=0; im_instr=0; rvalid ignored; stall_cycles=0.
6. Counter: hold if_req with gnt never asserted for 2^CNT_W+5 cycles (CNT_W=4 build) → stall_cycles saturates at 4'hF.
